seg7_bcd_scan_driver: RTL and testbench



---
 rtl/seg7_bcd_scan_driver_pkg.sv | 54 +++++
 rtl/seg7_bcd_scan_driver_if.sv | 22 ++
 rtl/seg7_bcd_scan_driver_bin2bcd_seq.sv | 90 +++++++++
 rtl/seg7_bcd_scan_driver.sv | 82 ++++++++
 tb/tb_seg7_bcd_scan_driver.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/seg7_bcd_scan_driver_pkg.sv
// Shared definitions for the BCD seven-segment scan driver.
// Contains active-low segment patterns {g,f,e,d,c,b,a}, the converter state
// encoding, and helpers for sizing the BCD accumulator and decoding digits.
package seg7_pkg;

  localparam logic [6:0] SEG_0   = 7'h40;
  localparam logic [6:0] SEG_1   = 7'h79;
  localparam logic [6:0] SEG_2   = 7'h24;
  localparam logic [6:0] SEG_3   = 7'h30;
  localparam logic [6:0] SEG_4   = 7'h19;
  localparam logic [6:0] SEG_5   = 7'h12;
  localparam logic [6:0] SEG_6   = 7'h02;
  localparam logic [6:0] SEG_7   = 7'h78;
  localparam logic [6:0] SEG_8   = 7'h00;
  localparam logic [6:0] SEG_9   = 7'h10;
  localparam logic [6:0] SEG_OFF = 7'h7F;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } conv_state_t;

  // Decimal digits needed to show the largest unsigned value of 'width' bits.
  function automatic int bcd_digits(input int width);
    longint unsigned max_v;
    int n;
    max_v = (64'd1 << width) - 64'd1;
    n = 1;
    while (max_v >= 64'd10) begin
      max_v = max_v / 64'd10;
      n++;
    end
    return n;
  endfunction

  // Active-low pattern for one BCD nibble; codes above 9 cannot occur and go blank.
  function automatic logic [6:0] seg7_decode(input logic [3:0] nib);
    case (nib)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_OFF;
    endcase
  endfunction

endpackage

// File: rtl/seg7_bcd_scan_driver_if.sv
// Load/display bundle between the game controller (master) and the
// seven-segment scan driver (slave).
interface seg7_bcd_scan_driver_if #(
  parameter int VALUE_WIDTH = 8,
  parameter int NUM_DIGITS  = 4
);
  logic [VALUE_WIDTH-1:0] value_in;
  logic                   value_valid;
  logic                   busy;
  logic [6:0]             seg;
  logic [NUM_DIGITS-1:0]  digit_select;

  modport master (
    output value_in, value_valid,
    input  busy, seg, digit_select
  );

  modport slave (
    input  value_in, value_valid,
    output busy, seg, digit_select
  );
endinterface

// File: rtl/seg7_bcd_scan_driver_bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one shift per clock.
// A strobe arriving while a conversion runs is parked in a one-deep pending
// slot (last strobe wins) and starts straight out of LATCH.
module bin2bcd_seq
  import seg7_pkg::*;
#(
  parameter int VALUE_WIDTH = 8,
  parameter int BCD_DIGITS  = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [VALUE_WIDTH-1:0]  value_in,
  input  logic                    value_valid,
  output logic                    busy,
  output logic [4*BCD_DIGITS-1:0] bcd_out
);

  localparam int BCD_W = 4 * BCD_DIGITS;
  localparam int CNT_W = $clog2(VALUE_WIDTH + 1);

  conv_state_t            state;
  logic [VALUE_WIDTH-1:0] sr;
  logic [BCD_W-1:0]       acc;
  logic [BCD_W-1:0]       adj;
  logic [CNT_W-1:0]       cnt;
  logic                   pend_vld;
  logic [VALUE_WIDTH-1:0] pend_val;

  // Add-3 correction on every nibble that would overflow past 9 when doubled.
  always_comb begin
    adj = acc;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (acc[4*i +: 4] >= 4'd5) adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
    end
  end

  // Conversion FSM with pending slot; display copy only happens in LATCH.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      sr       <= '0;
      acc      <= '0;
      cnt      <= '0;
      bcd_out  <= '0;
      pend_vld <= 1'b0;
      pend_val <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (value_valid) begin
            sr    <= value_in;
            acc   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          acc <= {adj[BCD_W-2:0], sr[VALUE_WIDTH-1]};
          sr  <= sr << 1;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(VALUE_WIDTH - 1)) state <= LATCH;
          if (value_valid) begin
            pend_vld <= 1'b1;
            pend_val <= value_in;
          end
        end
        LATCH: begin
          bcd_out  <= acc;
          pend_vld <= 1'b0;
          if (value_valid || pend_vld) begin
            sr    <= value_valid ? value_in : pend_val;
            acc   <= '0;
            cnt   <= '0;
            state <= SHIFT;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/seg7_bcd_scan_driver.sv
// Seven-segment BCD scan driver: converts a binary value to BCD and
// time-multiplexes NUM_DIGITS common-anode digits from the system clock,
// each digit enabled for SCAN_TICKS cycles.
// Build option: define SEG7_LZ_BLANK_EN to blank leading zeros (value 0
// still shows a single "0" in digit 0).
module seg7_bcd_scan_driver
  import seg7_pkg::*;
#(
  parameter int VALUE_WIDTH = 8,
  parameter int NUM_DIGITS  = 4,
  parameter int SCAN_TICKS  = 100_000
) (
  input  logic                    clk,
  input  logic                    reset,
  seg7_bcd_scan_driver_if.slave   bus
);

  localparam int BCD_DIGITS = bcd_digits(VALUE_WIDTH);
  localparam int BCD_W      = 4 * BCD_DIGITS;
  localparam int CNT_W      = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
  localparam int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [BCD_W-1:0] bcd;
  logic [CNT_W-1:0] scan_cnt;
  logic [IDX_W-1:0] digit_idx;
  logic [3:0]       cur_nib;
  logic             cur_blank;

  bin2bcd_seq #(
    .VALUE_WIDTH (VALUE_WIDTH),
    .BCD_DIGITS  (BCD_DIGITS)
  ) u_conv (
    .clk         (clk),
    .reset       (reset),
    .value_in    (bus.value_in),
    .value_valid (bus.value_valid),
    .busy        (bus.busy),
    .bcd_out     (bcd)
  );

  // Select the nibble for the scanned digit; digits above the BCD width read 0.
  always_comb begin
    cur_nib = 4'd0;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (digit_idx == IDX_W'(i)) cur_nib = bcd[4*i +: 4];
    end
  end

`ifdef SEG7_LZ_BLANK_EN
  int msd;
  // Blank every digit above the most significant nonzero one (digit 0 never blanks).
  always_comb begin
    msd = 0;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (bcd[4*i +: 4] != 4'd0) msd = i;
    end
    cur_blank = (int'(digit_idx) > msd);
  end
`else
  assign cur_blank = 1'b0;
`endif

  // Scan timing plus registered segment/digit outputs for the current index.
  always_ff @(posedge clk) begin
    if (reset) begin
      scan_cnt         <= '0;
      digit_idx        <= '0;
      bus.seg          <= SEG_OFF;
      bus.digit_select <= '1;
    end else begin
      bus.seg          <= cur_blank ? SEG_OFF : seg7_decode(cur_nib);
      bus.digit_select <= ~(NUM_DIGITS'(1) << digit_idx);
      if (scan_cnt == CNT_W'(SCAN_TICKS - 1)) begin
        scan_cnt  <= '0;
        digit_idx <= (digit_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : digit_idx + 1'b1;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg7_bcd_scan_driver.sv
// Directed bench for seg7_bcd_scan_driver (VALUE_WIDTH=8, NUM_DIGITS=4, SCAN_TICKS=4).
module tb_seg7_bcd_scan_driver;

  localparam int VW = 8;
  localparam int ND = 4;
  localparam int ST = 4;

`ifdef SEG7_LZ_BLANK_EN
  localparam logic [6:0] LZ = 7'h7F;
`else
  localparam logic [6:0] LZ = 7'h40;
`endif

  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int failures = 0;

  logic [6:0] cap [ND];
  logic [ND-1:0] cap_seen;
  logic [6:0] exp_d [ND];

  seg7_bcd_scan_driver_if #(.VALUE_WIDTH(VW), .NUM_DIGITS(ND)) bus ();

  seg7_bcd_scan_driver #(
    .VALUE_WIDTH (VW),
    .NUM_DIGITS  (ND),
    .SCAN_TICKS  (ST)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Record the segment pattern seen for each digit over a full scan round.
  task automatic capture();
    cap_seen = '0;
    for (int c = 0; c < ND * ST + 4; c++) begin
      tick();
      for (int i = 0; i < ND; i++) begin
        if (bus.digit_select === ~(4'b0001 << i)) begin
          cap[i] = bus.seg;
          cap_seen[i] = 1'b1;
        end
      end
    end
  endtask

  task automatic strobe_and_wait(input logic [VW-1:0] v, output int n);
    bus.value_in = v;
    bus.value_valid = 1'b1;
    tick();
    bus.value_valid = 1'b0;
    n = 0;
    while (bus.busy === 1'b1 && n < 40) begin
      n++;
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.value_in = 8'd99;
    bus.value_valid = 1'b1;
    tick(); tick(); tick();
    checks++;
    if (bus.busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b want=0", bus.busy); end
    checks++;
    if (bus.seg !== 7'h7F) begin failures++; $display("FAIL rst_seg got=%h want=7f", bus.seg); end
    checks++;
    if (bus.digit_select !== 4'hF) begin failures++; $display("FAIL rst_dsel got=%h want=f", bus.digit_select); end
    reset = 1'b0;
    bus.value_valid = 1'b0;
    tick();
    checks++;
    if (bus.digit_select !== 4'hE) begin failures++; $display("FAIL first_dsel got=%h want=e", bus.digit_select); end
    checks++;
    if (bus.seg !== 7'h40) begin failures++; $display("FAIL first_seg got=%h want=40", bus.seg); end
    checks++;
    if (bus.busy !== 1'b0) begin failures++; $display("FAIL rst_strobe_ignored busy=%b want=0", bus.busy); end
  endtask

  task automatic test_convert_42();
    int n;
    strobe_and_wait(8'd42, n);
    checks++;
    if (n != 9) begin failures++; $display("FAIL busy_len_42 got=%0d want=9", n); end
    tick(); tick();
    capture();
    exp_d[0] = 7'h24; exp_d[1] = 7'h19; exp_d[2] = LZ; exp_d[3] = LZ;
    for (int i = 0; i < ND; i++) begin
      checks++;
      if (!cap_seen[i] || cap[i] !== exp_d[i]) begin
        failures++; $display("FAIL disp42_d%0d got=%h seen=%b want=%h", i, cap[i], cap_seen[i], exp_d[i]);
      end
    end
  endtask

  task automatic test_convert_255();
    int n;
    strobe_and_wait(8'd255, n);
    checks++;
    if (n != VW + 1) begin failures++; $display("FAIL busy_len_255 got=%0d want=%0d", n, VW + 1); end
    tick(); tick();
    capture();
    exp_d[0] = 7'h12; exp_d[1] = 7'h12; exp_d[2] = 7'h24; exp_d[3] = LZ;
    for (int i = 0; i < ND; i++) begin
      checks++;
      if (!cap_seen[i] || cap[i] !== exp_d[i]) begin
        failures++; $display("FAIL disp255_d%0d got=%h seen=%b want=%h", i, cap[i], cap_seen[i], exp_d[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int n;
    int bad63;
    logic [6:0] mid [ND];
    logic [ND-1:0] mid_seen;
    mid_seen = '0;
    bad63 = 0;
    n = 0;
    bus.value_in = 8'd17;
    bus.value_valid = 1'b1;
    tick();
    if (bus.busy === 1'b1) n++;
    bus.value_in = 8'd63;
    tick();
    if (bus.busy === 1'b1) n++;
    bus.value_in = 8'd99;
    tick();
    bus.value_valid = 1'b0;
    while (bus.busy === 1'b1 && n < 60) begin
      n++;
      if (bus.seg === 7'h30 || bus.seg === 7'h02) bad63++;
      if (n >= 11) begin
        for (int i = 0; i < ND; i++) begin
          if (bus.digit_select === ~(4'b0001 << i)) begin
            mid[i] = bus.seg;
            mid_seen[i] = 1'b1;
          end
        end
      end
      tick();
    end
    checks++;
    if (n != 18) begin failures++; $display("FAIL b2b_busy_len got=%0d want=18", n); end
    exp_d[0] = 7'h78; exp_d[1] = 7'h79; exp_d[2] = LZ; exp_d[3] = LZ;
    checks++;
    if (mid_seen == '0) begin failures++; $display("FAIL b2b_mid_seen got=%b want=nonzero", mid_seen); end
    for (int i = 0; i < ND; i++) begin
      if (mid_seen[i]) begin
        checks++;
        if (mid[i] !== exp_d[i]) begin
          failures++; $display("FAIL b2b_mid17_d%0d got=%h want=%h", i, mid[i], exp_d[i]);
        end
      end
    end
    for (int c = 0; c < 24; c++) begin
      if (bus.seg === 7'h30 || bus.seg === 7'h02) bad63++;
      tick();
    end
    checks++;
    if (bad63 != 0) begin failures++; $display("FAIL b2b_63_shown got=%0d want=0", bad63); end
    capture();
    exp_d[0] = 7'h10; exp_d[1] = 7'h10; exp_d[2] = LZ; exp_d[3] = LZ;
    for (int i = 0; i < ND; i++) begin
      checks++;
      if (!cap_seen[i] || cap[i] !== exp_d[i]) begin
        failures++; $display("FAIL disp99_d%0d got=%h seen=%b want=%h", i, cap[i], cap_seen[i], exp_d[i]);
      end
    end
  endtask

  task automatic test_zero_and_scan();
    int n;
    logic [3:0] prev;
    logic [3:0] exp_sel [5];
    strobe_and_wait(8'd0, n);
    tick(); tick();
    capture();
    exp_d[0] = 7'h40; exp_d[1] = LZ; exp_d[2] = LZ; exp_d[3] = LZ;
    for (int i = 0; i < ND; i++) begin
      checks++;
      if (!cap_seen[i] || cap[i] !== exp_d[i]) begin
        failures++; $display("FAIL disp0_d%0d got=%h seen=%b want=%h", i, cap[i], cap_seen[i], exp_d[i]);
      end
    end
    n = 0;
    prev = bus.digit_select;
    tick();
    while (!(bus.digit_select === 4'hE && prev !== 4'hE) && n < 40) begin
      prev = bus.digit_select;
      tick();
      n++;
    end
    checks++;
    if (n >= 40) begin failures++; $display("FAIL scan_sync got=timeout want=digit0 entry"); end
    exp_sel[0] = 4'hE; exp_sel[1] = 4'hD; exp_sel[2] = 4'hB; exp_sel[3] = 4'h7; exp_sel[4] = 4'hE;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (bus.digit_select !== exp_sel[k]) begin
        failures++; $display("FAIL scan_seq%0d got=%h want=%h", k, bus.digit_select, exp_sel[k]);
      end
      for (int c = 0; c < ST; c++) tick();
    end
  endtask

  task automatic test_reset_mid_shift();
    int n;
    strobe_and_wait(8'd255, n);
    bus.value_in = 8'd200;
    bus.value_valid = 1'b1;
    tick();
    bus.value_valid = 1'b0;
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    checks++;
    if (bus.busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b want=0", bus.busy); end
    checks++;
    if (bus.seg !== 7'h7F) begin failures++; $display("FAIL midrst_seg got=%h want=7f", bus.seg); end
    checks++;
    if (bus.digit_select !== 4'hF) begin failures++; $display("FAIL midrst_dsel got=%h want=f", bus.digit_select); end
    reset = 1'b0;
    tick(); tick();
    checks++;
    if (bus.busy !== 1'b0) begin failures++; $display("FAIL postrst_busy got=%b want=0", bus.busy); end
    capture();
    exp_d[0] = 7'h40; exp_d[1] = LZ; exp_d[2] = LZ; exp_d[3] = LZ;
    for (int i = 0; i < ND; i++) begin
      checks++;
      if (!cap_seen[i] || cap[i] !== exp_d[i]) begin
        failures++; $display("FAIL postrst_d%0d got=%h seen=%b want=%h", i, cap[i], cap_seen[i], exp_d[i]);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.value_in = '0;
    bus.value_valid = 1'b0;
    test_reset();
    test_convert_42();
    test_convert_255();
    test_back_to_back();
    test_zero_and_scan();
    test_reset_mid_shift();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
